regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: requester 0 is the pipeline WB stage, requester 1 is a multi-cycle unit such as mul/div or a late load.
- Arbitrates each cycle with valid/ready handshakes and drops writes to x0 without using the port.
- Drives registered w_en/w_addr/w_data to the register file. The register file writes on negedge, so the port is stable for half a cycle before the write.
- Keeps a saturating contention counter for performance monitoring.

Parameters:
- N, 32, data width of the write data.
- FIXED_PRIO, 0, selects the arbitration policy. 0 = round-robin. 1 = requester 0 always wins.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  5  destination register of requester 0.
- req0_data  input  N  write data of requester 0.
- req0_ready  output  1  requester 0 request accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  5  destination register of requester 1.
- req1_data  input  N  write data of requester 1.
- req1_ready  output  1  requester 1 request accepted this cycle (combinational).
- w_en  output  1  register file write enable (registered).
- w_addr  output  5  register file write address (registered).
- w_data  output  N  register file write data (registered).
- conflict_cnt  output  CNT_W  saturating count of contention cycles.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - w_en=0, w_addr=0, w_data=0, conflict_cnt=0.
  - last_grant=1, so requester 0 wins the first contention.
  - req*_ready are combinational, but during any cycle with rst=1 both are forced to 0.
- Request classes:
  - A request is "real" if valid=1 and addr!=0.
  - A request is "null" if valid=1 and addr==0.
- Null requests:
  - Always accepted in the same cycle (ready=1).
  - Never drive the port and never change last_grant.
- Grant, real requests only:
  - Only one real request: it is granted.
  - Both real, FIXED_PRIO=1: requester 0 is granted.
  - Both real, FIXED_PRIO=0: the requester not equal to last_grant is granted. last_grant then updates to the granted index.
  - last_grant updates only on a real grant.
- Ready: req_i_ready = granted_i OR null_i. The losing requester keeps valid/addr/data stable until it sees ready.
- Latency:
  - A real request granted in cycle T appears at w_en=1 with its addr/data after posedge T+1.
  - It is written at the negedge of T+1 and is readable from the register file in T+2.
- Cycle with no real grant: w_en=0 after the next posedge; w_addr/w_data hold their previous values.
- Same destination on both requesters: arbitrated like any other contention, with no merging. Ordering between requesters is the producers' responsibility.
- conflict_cnt:
  - Increments each cycle both requests are real.
  - Saturates at all-ones and never wraps.
- Throughput: one real write per cycle, sustained.
- Reset mid-operation:
  - A pending registered write is discarded (w_en=0 after reset).
  - No request is acknowledged while rst=1.
  - Requesters must re-present after reset.

Test Plan:
- Reset then single write: req0_valid=1, addr=5, data=0xDEADBEEF for 1 cycle -> req0_ready=1 same cycle; next cycle w_en=1, w_addr=5, w_data=0xDEADBEEF; following cycle w_en=0.
- Round-robin contention (FIXED_PRIO=0): both valid for 4 cycles, req0 addr=3 data=0x11, req1 addr=7 data=0x22, each requester presenting a fresh write after every acceptance -> grants 0,1,0,1; w_addr sequence 3,7,3,7; conflict_cnt=4.
- Fixed priority (FIXED_PRIO=1): both valid, req0 held for 3 cycles -> req1_ready=0 for 3 cycles, then granted in cycle 4; w_addr 3,3,3,7; conflict_cnt=3.
- x0 handling: req0 addr=0 and req1 addr=9 data=0x55 in the same cycle -> both ready=1 that cycle; next cycle w_en=1, w_addr=9; last_grant=1; conflict_cnt unchanged.
- Saturation (CNT_W=4): 20 contention cycles -> conflict_cnt=15, no wrap.
- Reset mid-stream: rst=1 in the cycle after a grant -> w_en=0 after that posedge; ready=0 while rst=1; the first contention after reset is won by req0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the register file's single write port.
// Writes to x0 are acknowledged immediately and never reach the port.
module regfile_wb_arbiter #(
  parameter int N          = 32,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [N-1:0]     req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [N-1:0]     req1_data,
  output logic             req1_ready,
  output logic             w_en,
  output logic [4:0]       w_addr,
  output logic [N-1:0]     w_data,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Handshake: a request transfers in any cycle where valid and ready are both
  // high. ready is combinational and depends on valid/addr of both requesters;
  // an unaccepted requester holds valid, addr and data until it sees ready.

  logic             real0, real1, null0, null1;
  logic             both_real;
  logic             grant0, grant1;
  logic             last_grant_q, last_grant_d;
  logic             w_en_q, w_en_d;
  logic [4:0]       w_addr_q, w_addr_d;
  logic [N-1:0]     w_data_q, w_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign real0     = req0_valid && (req0_addr != 5'd0);
  assign real1     = req1_valid && (req1_addr != 5'd0);
  assign null0     = req0_valid && (req0_addr == 5'd0);
  assign null1     = req1_valid && (req1_addr == 5'd0);
  assign both_real = real0 && real1;

  // Under contention requester 0 wins if priority is fixed or requester 1 went last.
  assign grant0 = real0 && (!real1 || (FIXED_PRIO != 0) || last_grant_q);
  assign grant1 = real1 && !grant0;

  assign req0_ready = !rst && (grant0 || null0);
  assign req1_ready = !rst && (grant1 || null1);

  always_comb begin
    last_grant_d = last_grant_q;
    w_en_d       = grant0 || grant1;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    cnt_d        = cnt_q;
    if (grant0) begin
      last_grant_d = 1'b0;
      w_addr_d     = req0_addr;
      w_data_d     = req0_data;
    end else if (grant1) begin
      last_grant_d = 1'b1;
      w_addr_d     = req1_addr;
      w_data_d     = req1_data;
    end
    if (both_real && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      w_en_q       <= 1'b0;
      w_addr_q     <= 5'd0;
      w_data_q     <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign w_en         = w_en_q;
  assign w_addr       = w_addr_q;
  assign w_data       = w_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: round-robin, fixed-priority and
// narrow-counter instances share one set of request inputs.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;

  logic        rr_r0, rr_r1, rr_wen;
  logic [4:0]  rr_waddr;
  logic [31:0] rr_wdata;
  logic [15:0] rr_cnt;

  logic        fp_r0, fp_r1, fp_wen;
  logic [4:0]  fp_waddr;
  logic [31:0] fp_wdata;
  logic [15:0] fp_cnt;

  logic        sat_r0, sat_r1, sat_wen;
  logic [4:0]  sat_waddr;
  logic [31:0] sat_wdata;
  logic [3:0]  sat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N(32), .FIXED_PRIO(0), .CNT_W(16)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rr_r0),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rr_r1),
    .w_en(rr_wen), .w_addr(rr_waddr), .w_data(rr_wdata), .conflict_cnt(rr_cnt)
  );

  regfile_wb_arbiter #(.N(32), .FIXED_PRIO(1), .CNT_W(16)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(fp_r0),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(fp_r1),
    .w_en(fp_wen), .w_addr(fp_waddr), .w_data(fp_wdata), .conflict_cnt(fp_cnt)
  );

  regfile_wb_arbiter #(.N(32), .FIXED_PRIO(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(sat_r0),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(sat_r1),
    .w_en(sat_wen), .w_addr(sat_waddr), .w_data(sat_wdata), .conflict_cnt(sat_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_req(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);

    // Ready is suppressed while reset is asserted even with real requests present.
    chk("rst_ready0", 64'(rr_r0), 64'd0);
    chk("rst_ready1", 64'(rr_r1), 64'd0);
    tick();
    tick();
    chk("rst_wen", 64'(rr_wen), 64'd0);
    chk("rst_waddr", 64'(rr_waddr), 64'd0);
    chk("rst_wdata", 64'(rr_wdata), 64'd0);
    chk("rst_cnt", 64'(rr_cnt), 64'd0);
    rst = 1'b0;

    // Single write
    set_req(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    chk("single_ready0", 64'(rr_r0), 64'd1);
    chk("single_ready1", 64'(rr_r1), 64'd0);
    tick();
    chk("single_wen", 64'(rr_wen), 64'd1);
    chk("single_waddr", 64'(rr_waddr), 64'd5);
    chk("single_wdata", 64'(rr_wdata), 64'hDEADBEEF);
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("single_wen_off", 64'(rr_wen), 64'd0);
    chk("single_waddr_hold", 64'(rr_waddr), 64'd5);
    chk("single_wdata_hold", 64'(rr_wdata), 64'hDEADBEEF);

    // Round-robin contention: grants 0,1,0,1
    do_reset();
    set_req(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    chk("rr1_ready0", 64'(rr_r0), 64'd1);
    chk("rr1_ready1", 64'(rr_r1), 64'd0);
    tick();
    chk("rr1_waddr", 64'(rr_waddr), 64'd3);
    chk("rr1_wdata", 64'(rr_wdata), 64'h11);
    chk("rr2_ready0", 64'(rr_r0), 64'd0);
    chk("rr2_ready1", 64'(rr_r1), 64'd1);
    tick();
    chk("rr2_waddr", 64'(rr_waddr), 64'd7);
    chk("rr2_wdata", 64'(rr_wdata), 64'h22);
    chk("rr3_ready0", 64'(rr_r0), 64'd1);
    tick();
    chk("rr3_waddr", 64'(rr_waddr), 64'd3);
    chk("rr4_ready1", 64'(rr_r1), 64'd1);
    tick();
    chk("rr4_waddr", 64'(rr_waddr), 64'd7);
    chk("rr4_wen", 64'(rr_wen), 64'd1);
    chk("rr_cnt", 64'(rr_cnt), 64'd4);

    // Fixed priority: req1 starved for 3 cycles, then granted
    do_reset();
    set_req(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    for (int i = 0; i < 3; i++) begin
      chk("fp_ready0", 64'(fp_r0), 64'd1);
      chk("fp_ready1", 64'(fp_r1), 64'd0);
      tick();
      chk("fp_waddr_r0", 64'(fp_waddr), 64'd3);
    end
    set_req(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h22);
    chk("fp4_ready1", 64'(fp_r1), 64'd1);
    tick();
    chk("fp4_waddr", 64'(fp_waddr), 64'd7);
    chk("fp4_wdata", 64'(fp_wdata), 64'h22);
    chk("fp_cnt", 64'(fp_cnt), 64'd3);

    // x0 handling: null request never disturbs last_grant or the counter
    do_reset();
    set_req(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    tick();
    set_req(1'b1, 5'd0, 32'h99, 1'b1, 5'd9, 32'h55);
    chk("x0_ready0", 64'(rr_r0), 64'd1);
    chk("x0_ready1", 64'(rr_r1), 64'd1);
    tick();
    chk("x0_wen", 64'(rr_wen), 64'd1);
    chk("x0_waddr", 64'(rr_waddr), 64'd9);
    chk("x0_wdata", 64'(rr_wdata), 64'h55);
    chk("x0_cnt", 64'(rr_cnt), 64'd0);
    set_req(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    chk("x0_next_ready0", 64'(rr_r0), 64'd1);
    chk("x0_next_ready1", 64'(rr_r1), 64'd0);
    tick();
    chk("x0_next_waddr", 64'(rr_waddr), 64'd3);
    chk("x0_next_cnt", 64'(rr_cnt), 64'd1);
    set_req(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0);
    chk("null_only_ready0", 64'(rr_r0), 64'd1);
    tick();
    chk("null_only_wen", 64'(rr_wen), 64'd0);
    chk("null_only_waddr", 64'(rr_waddr), 64'd3);

    // Saturation on the 4-bit counter
    do_reset();
    set_req(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_cnt15", 64'(sat_cnt), 64'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_cnt20", 64'(sat_cnt), 64'd15);
    chk("wide_cnt20", 64'(rr_cnt), 64'd20);

    // Reset mid-stream
    do_reset();
    set_req(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    tick();
    chk("mid_wen_pre", 64'(rr_wen), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready0", 64'(rr_r0), 64'd0);
    chk("mid_rst_ready1", 64'(rr_r1), 64'd0);
    tick();
    chk("mid_rst_wen", 64'(rr_wen), 64'd0);
    chk("mid_rst_cnt", 64'(rr_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_after_ready0", 64'(rr_r0), 64'd1);
    chk("mid_after_ready1", 64'(rr_r1), 64'd0);
    tick();
    chk("mid_after_waddr", 64'(rr_waddr), 64'd3);
    chk("mid_after_cnt", 64'(rr_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
